// File: rtl/sram_arbiter.sv
// Time-shares the SRAM controller command port between the CPC and the supervisor.
// Optional abort timer in WAIT/S_WAIT is enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          cpc_req_i,
  input  logic [2:0]    cpc_cmd_i,
  input  logic [AW-1:0] cpc_A_i,
  input  logic [DW-1:0] cpc_D_i,
  output logic          cpc_done_o,
  output logic          cpc_halt_o,
  input  logic          sup_req_i,
  input  logic [2:0]    sup_cmd_i,
  input  logic [AW-1:0] sup_A_i,
  input  logic [DW-1:0] sup_D_i,
  output logic          sup_done_o,
  input  logic          pause_req_i,
  output logic          pause_ack_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_go_o,
  output logic [2:0]    mem_cmd_o,
  output logic [AW-1:0] mem_A_o,
  output logic [DW-1:0] mem_D_o,
  input  logic [DW-1:0] mem_D_i,
  input  logic          mem_busy_i,
  input  logic          mem_valid_i,
  output logic          err_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] PAUSED  = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  // The abort counter is 8 bits wide, so the limit must fit in 1..256.
  if (TIMEOUT == 0 || TIMEOUT > 256) begin : g_bad_timeout
    $error("sram_arbiter: TIMEOUT must be in 1..256");
  end

  logic [2:0] state;
  logic [2:0] state_next;
  logic       first_wait;
  logic       in_wait;
  logic       beat_done;
  logic       abort;
  logic       finish;
  logic       bus_to_sup;

  assign in_wait = (state == WAIT) || (state == S_WAIT);

  // Busy only rises the cycle after go, so a write cannot be judged complete on entry.
  always_comb begin
    beat_done = 1'b0;
    if (in_wait) begin
      beat_done = mem_cmd_o[1] ? mem_valid_i : (!mem_busy_i && !first_wait);
    end
  end

  assign finish = beat_done || abort;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pause_req_i)    state_next = PAUSED;
        else if (cpc_req_i) state_next = ISSUE;
      end
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (finish) state_next = pause_req_i ? PAUSED : IDLE;
      end
      PAUSED: begin
        if (sup_req_i)         state_next = S_ISSUE;
        else if (!pause_req_i) state_next = IDLE;
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (finish) state_next = PAUSED;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_to_sup = (state_next == PAUSED) || (state_next == S_ISSUE) ||
                      (state_next == S_WAIT);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      first_wait  <= 1'b0;
      mem_go_o    <= 1'b0;
      pause_ack_o <= 1'b0;
      cpc_halt_o  <= 1'b0;
      cpc_done_o  <= 1'b0;
      sup_done_o  <= 1'b0;
      rdata_o     <= '0;
      mem_cmd_o   <= '0;
      mem_A_o     <= '0;
      mem_D_o     <= '0;
    end else begin
      state       <= state_next;
      first_wait  <= (state == ISSUE) || (state == S_ISSUE);
      mem_go_o    <= (state_next == ISSUE) || (state_next == S_ISSUE);
      pause_ack_o <= bus_to_sup;
      cpc_halt_o  <= bus_to_sup;
      cpc_done_o  <= (state == WAIT) && finish;
      sup_done_o  <= (state == S_WAIT) && finish;
      if (state == IDLE && state_next == ISSUE) begin
        mem_cmd_o <= cpc_cmd_i;
        mem_A_o   <= cpc_A_i;
        mem_D_o   <= cpc_D_i;
      end else if (state == PAUSED && state_next == S_ISSUE) begin
        mem_cmd_o <= sup_cmd_i;
        mem_A_o   <= sup_A_i;
        mem_D_o   <= sup_D_i;
      end
      if (abort) begin
        rdata_o <= '1;
      end else if (beat_done && mem_cmd_o[1]) begin
        rdata_o <= mem_D_i;
      end
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // A genuine completion in the limit cycle wins over the abort.
  assign abort = in_wait && !beat_done && (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tmo_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      if (state == ISSUE || state == S_ISSUE) begin
        tmo_cnt <= '0;
      end else if (in_wait) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (abort) begin
        err_o <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

endmodule
